// File: rtl/adam_aes_pkg.sv
// adam_aes_pkg
//   Shared types and helpers for the AES CTR keystream sequencer.
//   - block_t     : 128-bit AES block
//   - ctr_state_e : sequencer states (IDLE, START, WAIT, KS)
//   - ctr_mask    : mask covering the low 'width' counter bits
//   - ctr_inc     : increment low 'width' bits modulo 2^width, upper bits kept
//   - ctr_wraps   : 1 when the low 'width' bits are all ones (next inc wraps)
package adam_aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    KS    = 2'd3
  } ctr_state_e;

  function automatic block_t ctr_mask(input int unsigned width);
    block_t m;
    if (width >= 128) m = '1;
    else              m = (block_t'(1) << width) - block_t'(1);
    return m;
  endfunction

  function automatic block_t ctr_inc(input block_t ctr, input int unsigned width);
    block_t m;
    m = ctr_mask(width);
    // Carry out of the counter field is masked off so the nonce never changes.
    return (ctr & ~m) | ((ctr + block_t'(1)) & m);
  endfunction

  function automatic logic ctr_wraps(input block_t ctr, input int unsigned width);
    block_t m;
    m = ctr_mask(width);
    return ((ctr & m) == m);
  endfunction

endpackage

// File: rtl/adam_aes_ctr_keystream.sv
// adam_aes_ctr_keystream
//   CTR-mode sequencer around the AES encipher block. Presents the counter
//   block to the encipher, captures the enciphered result as keystream and
//   XORs it with a valid/ready stream of 128-bit words.
//
//   Ports
//     clk, reset_n            clock, async active-low reset
//     init, iv                start a new message with initial counter iv
//     enc_next, enc_block     start pulse / counter block to the encipher
//     enc_ready,enc_new_block encipher ready / result
//     in_valid/in_ready/in_data/in_last      input word stream
//     out_valid/out_ready/out_data/out_last  output word stream
//     busy                    sequencer not idle
//     err_wrap                sticky counter-wrap flag, cleared by init
//
//   state | meaning
//   IDLE  | no message active, input refused
//   START | waiting for encipher ready to issue enc_next
//   WAIT  | encipher running, waiting for its result
//   KS    | keystream held, waiting to accept one input word
module adam_aes_ctr_keystream
  import adam_aes_pkg::*;
#(
  parameter int unsigned CTR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [127:0] iv,
  output logic         enc_next,
  output logic [127:0] enc_block,
  input  logic         enc_ready,
  input  logic [127:0] enc_new_block,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         err_wrap
);

  ctr_state_e state_q, state_d;
  block_t     ctr_q, ctr_d;
  block_t     ks_q, ks_d;
  logic       drop_q, drop_d;
  logic       err_wrap_q, err_wrap_d;
  logic       out_valid_q, out_valid_d;
  block_t     out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  logic       accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ctr_q       <= '0;
      ks_q        <= '0;
      drop_q      <= 1'b0;
      err_wrap_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      ks_q        <= ks_d;
      drop_q      <= drop_d;
      err_wrap_q  <= err_wrap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    ks_d        = ks_q;
    drop_d      = drop_q;
    err_wrap_d  = err_wrap_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    enc_next    = 1'b0;
    in_ready    = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      IDLE: ;
      START: begin
        if (drop_q) begin
          // The first ready after an init-in-WAIT is the stale completion;
          // swallow it and issue on a later cycle.
          if (enc_ready) drop_d = 1'b0;
        end else if (enc_ready) begin
          enc_next = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (enc_ready) begin
          ks_d    = enc_new_block;
          state_d = KS;
        end
      end
      KS: begin
        in_ready = !out_valid_q || out_ready;
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          ctr_d   = ctr_inc(ctr_q, CTR_WIDTH);
          if (ctr_wraps(ctr_q, CTR_WIDTH)) err_wrap_d = 1'b1;
          state_d = in_last ? IDLE : START;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ ks_q;
      out_last_d  = in_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // init overrides counter and state; an acceptance in the same cycle still
    // completes with the old keystream, and the output register is untouched.
    if (init) begin
      ctr_d      = iv;
      err_wrap_d = 1'b0;
      state_d    = START;
      enc_next   = 1'b0;
      if (state_q == WAIT) drop_d = 1'b1;
    end
  end

  assign enc_block = ctr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign err_wrap  = err_wrap_q;

endmodule

// File: tb/tb_adam_aes_ctr_keystream.sv
module tb_adam_aes_ctr_keystream;

  localparam int ENC_LAT = 4;

  localparam logic [127:0] IV   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV2  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1   = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2   = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] IVW  = 128'h00112233445566778899aabbffffffff;
  localparam logic [127:0] IVW2 = 128'h00112233445566778899aabb00000000;
  localparam logic [127:0] IVA  = 128'h00000000000000000000000000000a0a;

  logic         clk;
  logic         reset_n;
  logic         init;
  logic [127:0] iv;
  logic         enc_next;
  logic [127:0] enc_block;
  logic         enc_ready;
  logic [127:0] enc_new_block;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic         err_wrap;

  int n_checks = 0;
  int n_errors = 0;

  adam_aes_ctr_keystream #(.CTR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .init(init), .iv(iv),
    .enc_next(enc_next), .enc_block(enc_block),
    .enc_ready(enc_ready), .enc_new_block(enc_new_block),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err_wrap(err_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // AES-128 (key 2b7e1516...) output blocks from SP800-38A for the two known
  // counters; any other counter gets a fixed, easily hand-derived mixing.
  function automatic logic [127:0] ks_of(input logic [127:0] c);
    case (c)
      IV:      return 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
      IV2:     return 128'h362b7c3c6773516318a077d7fc5073ae;
      default: return {c[63:0], c[127:64]} ^ 128'h0123456789abcdeffedcba9876543210;
    endcase
  endfunction

  // Encipher model: ready drops the cycle after next, result after ENC_LAT.
  int           enc_cnt;
  logic [127:0] enc_cap;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_ready     <= 1'b1;
      enc_cnt       <= 0;
      enc_new_block <= '0;
      enc_cap       <= '0;
    end else if (enc_cnt != 0) begin
      enc_cnt <= enc_cnt - 1;
      if (enc_cnt == 1) begin
        enc_ready     <= 1'b1;
        enc_new_block <= ks_of(enc_cap);
      end
    end else if (enc_next) begin
      enc_ready <= 1'b0;
      enc_cnt   <= ENC_LAT;
      enc_cap   <= enc_block;
    end
  end

  int           nxt_cnt = 0;
  logic [127:0] last_blk = '0;
  logic [127:0] xfers[$];
  always @(posedge clk) begin
    if (reset_n) begin
      if (enc_next) begin
        nxt_cnt  = nxt_cnt + 1;
        last_blk = enc_block;
      end
      if (out_valid && out_ready) xfers.push_back(out_data);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_init(input logic [127:0] v);
    init = 1'b1;
    iv   = v;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  task automatic send_word(input logic [127:0] d, input logic l, output logic ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic         ok;
    int           n0;
    int           q0;
    int           bad;
    logic [127:0] k1;
    logic [127:0] got0, got1;

    reset_n   = 1'b1;
    init      = 1'b0;
    iv        = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #3 reset_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_enc_next",  enc_next,  0);
    chk("rst_enc_block", enc_block, 0);
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_busy",      busy,      0);
    chk("rst_err_wrap",  err_wrap,  0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // SP800-38A F.5.1, single word
    do_init(IV);
    @(negedge clk);
    chk("f51_busy_start", busy, 1);
    n0 = nxt_cnt;
    send_word(P1, 1'b1, ok);
    chk("f51_accept",    ok,        1);
    chk("f51_out_data",  out_data,  C1);
    chk("f51_out_last",  out_last,  1);
    chk("f51_out_valid", out_valid, 1);
    @(negedge clk);
    chk("f51_busy_end",     busy,     0);
    chk("f51_in_ready_end", in_ready, 0);
    chk("f51_next_pulses",  nxt_cnt - n0, 1);

    // Counter increment, two words
    do_init(IV);
    n0 = nxt_cnt;
    send_word(P1, 1'b0, ok);
    chk("inc_accept1",   ok,       1);
    chk("inc_out_data1", out_data, C1);
    chk("inc_out_last1", out_last, 0);
    send_word(P2, 1'b1, ok);
    chk("inc_accept2",    ok,       1);
    chk("inc_out_data2",  out_data, C2);
    chk("inc_out_last2",  out_last, 1);
    chk("inc_enc_block2", last_blk, IV2);
    chk("inc_next_pulses", nxt_cnt - n0, 2);

    // Counter wrap in the low 32 bits
    do_init(IVW);
    send_word(128'h0, 1'b0, ok);
    chk("wrap_accept1",   ok,       1);
    chk("wrap_out_data1", out_data, ks_of(IVW));
    chk("wrap_err_set",   err_wrap, 1);
    send_word(128'hffffffffffffffffffffffffffffffff, 1'b1, ok);
    chk("wrap_accept2",    ok,       1);
    chk("wrap_enc_block2", last_blk, IVW2);
    chk("wrap_out_data2",  out_data, ~ks_of(IVW2));
    chk("wrap_err_hold",   err_wrap, 1);
    do_init(IV);
    chk("wrap_err_clear", err_wrap, 0);

    // Backpressure with a pending result
    out_ready = 1'b0;
    q0 = xfers.size();
    send_word(P1, 1'b0, ok);
    chk("bp_accept1", ok, 1);
    in_valid = 1'b1;
    in_data  = P2;
    in_last  = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== C1 || in_ready !== 1'b0) bad++;
    end
    chk("bp_hold_stable", bad, 0);
    chk("bp_busy_ks", busy, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_out_data2",  out_data,  C2);
    chk("bp_out_valid2", out_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    got0 = (xfers.size() > q0)     ? xfers[q0]     : '0;
    got1 = (xfers.size() > q0 + 1) ? xfers[q0 + 1] : '0;
    chk("bp_xfer_count", xfers.size() - q0, 2);
    chk("bp_xfer0", got0, C1);
    chk("bp_xfer1", got1, C2);

    // init during WAIT: first result discarded
    do_init(IVA);
    n0 = nxt_cnt;
    @(posedge clk); #1;
    @(negedge clk);
    chk("iw_in_wait", enc_ready, 0);
    chk("iw_in_ready_wait", in_ready, 0);
    do_init(IV);
    send_word(P1, 1'b1, ok);
    chk("iw_accept",      ok,       1);
    chk("iw_out_data",    out_data, C1);
    chk("iw_enc_block",   last_blk, IV);
    chk("iw_next_pulses", nxt_cnt - n0, 2);
    @(posedge clk); #1;

    // Asynchronous reset in WAIT
    do_init(IVW);
    @(posedge clk); #1;
    k1 = enc_block;
    chk("rw_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rw_busy",      busy,      0);
    chk("rw_enc_next",  enc_next,  0);
    chk("rw_enc_block", enc_block, 0);
    chk("rw_out_valid", out_valid, 0);
    chk("rw_out_data",  out_data,  0);
    chk("rw_out_last",  out_last,  0);
    chk("rw_in_ready",  in_ready,  0);
    chk("rw_err_wrap",  err_wrap,  0);
    @(posedge clk); #1;
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in_data  = P1;
    in_last  = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("rw_refuse_until_init", bad, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    do_init(IV);
    send_word(P1, 1'b1, ok);
    chk("rw_recover_accept", ok, 1);
    chk("rw_recover_data", out_data, C1);
    if (k1 !== IVW) begin
      n_checks++;
      n_errors++;
      $error("FAIL rw_enc_block_before: observed %h expected %h", k1, IVW);
    end else begin
      n_checks++;
    end
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
